// File: rtl/reg_file_scoreboard.sv
// Scalar/vector register file with a per-register busy scoreboard and dependency stall.
// Optional feature: define RF_WB_BYPASS_EN to forward same-cycle commits to reads and to the hazard check.
module reg_file_scoreboard #(
   parameter int SREG_COUNT = 16,
   parameter int VREG_COUNT = 16,
   parameter int IDX_W      = 6,
   parameter int REG_WIDTH  = 16,
   parameter int VREG_WIDTH = 64
) (
   input  logic                  I_CLOCK,
   input  logic                  I_RESET,
   input  logic                  I_WriteBackEnable,
   input  logic                  I_VWriteBackEnable,
   input  logic [IDX_W-1:0]      I_WriteBackRegIdx,
   input  logic [REG_WIDTH-1:0]  I_WriteBackData,
   input  logic [VREG_WIDTH-1:0] I_VWriteBackData,
   input  logic                  I_IssueValid,
   input  logic [IDX_W-1:0]      I_Src1Idx,
   input  logic [IDX_W-1:0]      I_Src2Idx,
   input  logic                  I_Src1Vec,
   input  logic                  I_Src2Vec,
   input  logic                  I_Src1Used,
   input  logic                  I_Src2Used,
   input  logic                  I_DestValid,
   input  logic                  I_DestVec,
   input  logic [IDX_W-1:0]      I_DestIdx,
   output logic [VREG_WIDTH-1:0] O_Src1Data,
   output logic [VREG_WIDTH-1:0] O_Src2Data,
   output logic                  O_DepStall,
   output logic                  O_IssueAccept
);

   localparam int S_AW = $clog2(SREG_COUNT);
   localparam int V_AW = $clog2(VREG_COUNT);
   localparam logic [IDX_W-1:0] S_LIMIT = IDX_W'(SREG_COUNT);
   localparam logic [IDX_W-1:0] V_LIMIT = IDX_W'(VREG_COUNT);

   logic [REG_WIDTH-1:0]  sreg [SREG_COUNT];
   logic [VREG_WIDTH-1:0] vreg [VREG_COUNT];
   logic [SREG_COUNT-1:0] sbusy;
   logic [VREG_COUNT-1:0] vbusy;

   // Busy view seen by the hazard check this cycle (commit-cleared when bypassing).
   logic [SREG_COUNT-1:0] sbusy_eff;
   logic [VREG_COUNT-1:0] vbusy_eff;

   logic [1:0][IDX_W-1:0]      src_idx;
   logic [1:0]                 src_vec;
   logic [1:0]                 src_used;
   logic [1:0][VREG_WIDTH-1:0] src_data;
   logic [1:0]                 src_hazard;
   logic                       dest_hazard;
   logic                       stall_raw;

   function automatic logic s_in(input logic [IDX_W-1:0] idx);
      return idx < S_LIMIT;
   endfunction

   function automatic logic v_in(input logic [IDX_W-1:0] idx);
      return idx < V_LIMIT;
   endfunction

   function automatic logic [S_AW-1:0] s_ptr(input logic [IDX_W-1:0] idx);
      return idx[S_AW-1:0];
   endfunction

   function automatic logic [V_AW-1:0] v_ptr(input logic [IDX_W-1:0] idx);
      return idx[V_AW-1:0];
   endfunction

   logic s_commit, v_commit;
   assign s_commit = I_WriteBackEnable  & s_in(I_WriteBackRegIdx);
   assign v_commit = I_VWriteBackEnable & v_in(I_WriteBackRegIdx);

   assign src_idx  = {I_Src2Idx, I_Src1Idx};
   assign src_vec  = {I_Src2Vec, I_Src1Vec};
   assign src_used = {I_Src2Used, I_Src1Used};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
      sbusy_eff = sbusy;
      vbusy_eff = vbusy;
`ifdef RF_WB_BYPASS_EN
      if (s_commit) sbusy_eff[s_ptr(I_WriteBackRegIdx)] = 1'b0;
      if (v_commit) vbusy_eff[v_ptr(I_WriteBackRegIdx)] = 1'b0;
`endif
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         src_data[i]   = '0;
         src_hazard[i] = 1'b0;
         if (src_vec[i]) begin
            if (v_in(src_idx[i])) begin
               src_data[i]   = vreg[v_ptr(src_idx[i])];
               src_hazard[i] = src_used[i] & vbusy_eff[v_ptr(src_idx[i])];
`ifdef RF_WB_BYPASS_EN
               if (v_commit && I_WriteBackRegIdx == src_idx[i]) src_data[i] = I_VWriteBackData;
`endif
            end
         end else if (s_in(src_idx[i])) begin
            src_data[i]   = {{(VREG_WIDTH-REG_WIDTH){1'b0}}, sreg[s_ptr(src_idx[i])]};
            src_hazard[i] = src_used[i] & sbusy_eff[s_ptr(src_idx[i])];
`ifdef RF_WB_BYPASS_EN
            if (s_commit && I_WriteBackRegIdx == src_idx[i])
               src_data[i] = {{(VREG_WIDTH-REG_WIDTH){1'b0}}, I_WriteBackData};
`endif
         end
      end
   end

   always_comb begin
      dest_hazard = 1'b0;
      if (I_DestValid) begin
         if (I_DestVec) dest_hazard = v_in(I_DestIdx) & vbusy_eff[v_ptr(I_DestIdx)];
         else           dest_hazard = s_in(I_DestIdx) & sbusy_eff[s_ptr(I_DestIdx)];
      end
   end

   assign stall_raw     = |src_hazard | dest_hazard;
   assign O_DepStall    = ~I_RESET & I_IssueValid & stall_raw;
   assign O_IssueAccept = ~I_RESET & I_IssueValid & ~stall_raw;
   assign O_Src1Data    = I_RESET ? '0 : src_data[0];
   assign O_Src2Data    = I_RESET ? '0 : src_data[1];

   always_ff @(posedge I_CLOCK) begin
      if (I_RESET) begin
         // NOTE: the register contents are architecturally zero after reset, so the arrays are cleared too.
         for (int i = 0; i < SREG_COUNT; i++) sreg[i] <= '0;
         for (int i = 0; i < VREG_COUNT; i++) vreg[i] <= '0;
         sbusy <= '0;
         vbusy <= '0;
      end else begin
         if (s_commit) begin
            sreg[s_ptr(I_WriteBackRegIdx)]  <= I_WriteBackData;
            sbusy[s_ptr(I_WriteBackRegIdx)] <= 1'b0;
         end
         if (v_commit) begin
            vreg[v_ptr(I_WriteBackRegIdx)]  <= I_VWriteBackData;
            vbusy[v_ptr(I_WriteBackRegIdx)] <= 1'b0;
         end
         // NOTE: the issue-set comes after the commit-clear; the later non-blocking write wins, so set wins.
         if (O_IssueAccept && I_DestValid) begin
            if (I_DestVec) begin
               if (v_in(I_DestIdx)) vbusy[v_ptr(I_DestIdx)] <= 1'b1;
            end else if (s_in(I_DestIdx)) begin
               sbusy[s_ptr(I_DestIdx)] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed self-checking bench for reg_file_scoreboard; expectations follow the RF_WB_BYPASS_EN build setting.
module tb_reg_file_scoreboard;

   localparam int IDX_W = 6;
`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             wb_en, vwb_en;
   logic [IDX_W-1:0] wb_idx;
   logic [15:0]      wb_data;
   logic [63:0]      vwb_data;
   logic             issue_valid;
   logic [IDX_W-1:0] src1_idx, src2_idx, dest_idx;
   logic             src1_vec, src2_vec, src1_used, src2_used;
   logic             dest_valid, dest_vec;
   logic [63:0]      src1_data, src2_data;
   logic             dep_stall, issue_accept;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   reg_file_scoreboard dut (
      .I_CLOCK(clk), .I_RESET(rst),
      .I_WriteBackEnable(wb_en), .I_VWriteBackEnable(vwb_en),
      .I_WriteBackRegIdx(wb_idx), .I_WriteBackData(wb_data), .I_VWriteBackData(vwb_data),
      .I_IssueValid(issue_valid),
      .I_Src1Idx(src1_idx), .I_Src2Idx(src2_idx),
      .I_Src1Vec(src1_vec), .I_Src2Vec(src2_vec),
      .I_Src1Used(src1_used), .I_Src2Used(src2_used),
      .I_DestValid(dest_valid), .I_DestVec(dest_vec), .I_DestIdx(dest_idx),
      .O_Src1Data(src1_data), .O_Src2Data(src2_data),
      .O_DepStall(dep_stall), .O_IssueAccept(issue_accept)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      wb_en = 0; vwb_en = 0; wb_idx = '0; wb_data = '0; vwb_data = '0;
      issue_valid = 0; src1_idx = '0; src2_idx = '0; src1_vec = 0; src2_vec = 0;
      src1_used = 0; src2_used = 0; dest_valid = 0; dest_vec = 0; dest_idx = '0;
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      // 1. Reset: outputs gated even with an issue presented.
      issue_valid = 1; src1_idx = 6'd3; src1_used = 1; dest_valid = 1; dest_idx = 6'd3;
      tick();
      settle();
      check("rst_stall", {63'd0, dep_stall}, 64'd0);
      check("rst_accept", {63'd0, issue_accept}, 64'd0);
      idle();
      tick();
      rst = 1'b0;
      src1_idx = 6'd3; src2_idx = 6'd2; src2_vec = 1; src1_used = 1; src2_used = 1;
      issue_valid = 1;
      settle();
      check("s3_after_reset", src1_data, 64'd0);
      check("v2_after_reset", src2_data, 64'd0);
      check("no_stall_after_reset", {63'd0, dep_stall}, 64'd0);
      idle();
      tick();

      // 2. RAW on S5, resolved by commit.
      issue_valid = 1; dest_valid = 1; dest_idx = 6'd5;
      settle();
      check("issue_dest_s5", {63'd0, issue_accept}, 64'd1);
      tick();
      idle();
      issue_valid = 1; src1_idx = 6'd5; src1_used = 1;
      settle();
      check("raw_s5_stall", {63'd0, dep_stall}, 64'd1);
      wb_en = 1; wb_idx = 6'd5; wb_data = 16'h1234;
      settle();
      check("raw_s5_commit_accept", {63'd0, issue_accept}, {63'd0, BYP});
      check("raw_s5_commit_stall", {63'd0, dep_stall}, {63'd0, !BYP});
      check("raw_s5_commit_data", src1_data, BYP ? 64'h1234 : 64'h0);
      tick();
      wb_en = 0;
      settle();
      check("raw_s5_after_accept", {63'd0, issue_accept}, 64'd1);
      check("raw_s5_after_data", src1_data, 64'h1234);
      idle();
      tick();

      // 3. Simultaneous scalar and vector commit at the same index.
      wb_en = 1; vwb_en = 1; wb_idx = 6'd1;
      wb_data = 16'h00FF; vwb_data = 64'hDEAD_BEEF_0123_4567;
      tick();
      idle();
      src1_idx = 6'd1; src2_idx = 6'd1; src2_vec = 1;
      settle();
      check("s1_read", src1_data, 64'h0000_0000_0000_00FF);
      check("v1_read", src2_data, 64'hDEAD_BEEF_0123_4567);
      idle();
      tick();

      // 4. WAW on V4.
      issue_valid = 1; dest_valid = 1; dest_vec = 1; dest_idx = 6'd4;
      settle();
      check("issue_dest_v4", {63'd0, issue_accept}, 64'd1);
      tick();
      settle();
      check("waw_v4_stall", {63'd0, dep_stall}, 64'd1);
      vwb_en = 1; wb_idx = 6'd4; vwb_data = 64'h0404_0404_0404_0404;
      settle();
      check("waw_v4_commit_accept", {63'd0, issue_accept}, {63'd0, BYP});
      tick();
      vwb_en = 0;
      settle();
      // Bypass build: the re-issue set V4 busy again. Otherwise the commit freed it.
      check("v4_busy_after", {63'd0, dep_stall}, {63'd0, BYP});
      issue_valid = 0; dest_valid = 0;
      src1_idx = 6'd4; src1_vec = 1;
      settle();
      check("v4_data", src1_data, 64'h0404_0404_0404_0404);
      idle();
      tick();

      // Set wins over same-cycle clear on a non-busy S9.
      wb_en = 1; wb_idx = 6'd9; wb_data = 16'h0009;
      issue_valid = 1; dest_valid = 1; dest_idx = 6'd9;
      settle();
      check("s9_set_clear_accept", {63'd0, issue_accept}, 64'd1);
      tick();
      idle();
      issue_valid = 1; src1_idx = 6'd9; src1_used = 1;
      settle();
      check("s9_still_busy", {63'd0, dep_stall}, 64'd1);
      check("s9_data", src1_data, 64'h0009);
      idle();
      tick();

      // 5. Reset mid-operation with a commit to busy S7.
      issue_valid = 1; dest_valid = 1; dest_idx = 6'd7;
      settle();
      check("issue_dest_s7", {63'd0, issue_accept}, 64'd1);
      tick();
      idle();
      rst = 1;
      wb_en = 1; wb_idx = 6'd7; wb_data = 16'hAAAA;
      issue_valid = 1; src1_idx = 6'd7; src1_used = 1; src2_idx = 6'd1;
      settle();
      check("rst_mid_stall", {63'd0, dep_stall}, 64'd0);
      check("rst_mid_read", src2_data, 64'd0);
      tick();
      rst = 0;
      wb_en = 0;
      settle();
      check("s7_no_stall", {63'd0, dep_stall}, 64'd0);
      check("s7_accept", {63'd0, issue_accept}, 64'd1);
      check("s7_zero", src1_data, 64'd0);
      check("s1_cleared", src2_data, 64'd0);
      idle();
      tick();

      // 6. Out-of-range index 20 (low bits alias S4).
      wb_en = 1; wb_idx = 6'd4; wb_data = 16'h4444;
      tick();
      idle();
      issue_valid = 1; dest_valid = 1; dest_idx = 6'd4;
      settle();
      check("issue_dest_s4", {63'd0, issue_accept}, 64'd1);
      tick();
      idle();
      wb_en = 1; wb_idx = 6'd20; wb_data = 16'hBEEF;
      tick();
      idle();
      issue_valid = 1; src1_idx = 6'd4; src1_used = 1; src2_idx = 6'd20;
      settle();
      check("s4_unchanged", src1_data, 64'h4444);
      check("s4_still_busy", {63'd0, dep_stall}, 64'd1);
      check("s20_read_zero", src2_data, 64'd0);
      idle();
      issue_valid = 1; dest_valid = 1; dest_idx = 6'd20;
      settle();
      check("dest_s20_accept", {63'd0, issue_accept}, 64'd1);
      tick();
      idle();
      issue_valid = 1; src1_idx = 6'd20; src1_used = 1; src2_idx = 6'd20; src2_vec = 1; src2_used = 1;
      settle();
      check("s20_never_busy", {63'd0, dep_stall}, 64'd0);
      check("v20_read_zero", src2_data, 64'd0);
      idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
